// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the next-PC generator.
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
  typedef enum logic [2:0] {SRC_HOLD, SRC_TRAP, SRC_REDIR, SRC_JMP, SRC_RET, SRC_BR, SRC_SEQ} src_e;
  localparam int unsigned STEP_C = 2;
  localparam int unsigned STEP_W = 4;
  function automatic logic is_target_src(input src_e s);
    return s inside {SRC_TRAP, SRC_REDIR, SRC_JMP, SRC_RET, SRC_BR};
  endfunction
endpackage

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [PW:0] cnt_q, cnt_d;
  assign top_idx = ptr_q - PW'(1);
  // pop+push together rewrites the current top in place
  assign wr_idx = pop_i ? top_idx : ptr_q;
  always_comb begin
    ptr_d = (push_i & pop_i) ? ptr_q : push_i ? ptr_q + PW'(1) : pop_i ? top_idx : ptr_q;
    cnt_d = (push_i & pop_i) ? cnt_q : push_i ? ((cnt_q == FULL) ? cnt_q : cnt_q + 1'b1) : pop_i ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= data_i;
  end
  assign top_o   = mem_q[top_idx];
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: next-PC generator for the fetch front end (trap > redirect > jump > return > branch > sequential).
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  input  logic            is_compressed_i,
  input  logic            branch_en,
  input  logic            jmp_en,
  input  logic [XLEN-1:0] imm,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  output logic            misalign_o
);
  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
  state_e state_q, state_d;
  src_e src;
  logic [XLEN-1:0] pc_q, pc_d, step, seq_pc, rel_pc, ras_top, target;
  logic mis_q, mis_d, accept, active, ras_hit, tgt_sel;
  assign active = state_q != BOOT;
  assign accept = fetch_valid_o & fetch_ready_i;
  assign step   = (IALIGN == 16 && is_compressed_i) ? XLEN'(STEP_C) : XLEN'(STEP_W);
  assign seq_pc = pc_q + step;
  assign rel_pc = pc_q + imm;
`ifdef PC_GEN_RAS_EN
  logic ras_empty, ras_ok;
  // trap/redirect cycles leave the stack untouched
  assign ras_ok  = accept & ~trap_i & ~redirect_i;
  assign ras_hit = ret_i & ~ras_empty;
  pc_gen_ras #(.W(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_ok & call_i),
    .pop_i   (ras_ok & ras_hit),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );
`else
  logic unused_hints;
  logic [31:0] unused_depth;
  assign unused_hints = call_i ^ ret_i;
  assign unused_depth = RAS_DEPTH;
  assign ras_hit      = 1'b0;
  assign ras_top      = '0;
`endif
  assign src = !active ? SRC_HOLD : trap_i ? SRC_TRAP : redirect_i ? SRC_REDIR : !accept ? SRC_HOLD :
               jmp_en ? SRC_JMP : ras_hit ? SRC_RET : branch_en ? SRC_BR : SRC_SEQ;
  always_comb begin
    tgt_sel = is_target_src(src);
    target  = (src == SRC_TRAP) ? trap_vec_i : (src == SRC_REDIR) ? redirect_pc_i :
              (src == SRC_RET) ? ras_top : rel_pc;
    pc_d    = (src == SRC_HOLD) ? pc_q : tgt_sel ? (target & ~ALIGN_MASK) : seq_pc;
    mis_d   = tgt_sel & |(target & ALIGN_MASK);
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == BOOT || trap_i || redirect_i) ? RUN :
              (state_q == RUN && halt_i) ? HALTED : state_q;
  end
  always_comb begin
    fetch_valid_o = state_q == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end
  assign pc_o       = pc_q;
  assign misalign_o = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: pc_gen with IALIGN=32 (index 0) and IALIGN=16 (index 1) driven by shared directed and
// random stimulus, checked every cycle against a behavioural model plus literal anchors.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h8000_0000;
  localparam int DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, ready, comp, br, jmp, call, ret, redir, trap, halt;
  logic [31:0] imm, rpc, tvec;
  logic [1:0] v, mis;
  logic [1:0][31:0] pc;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int m_st [2];
  logic [31:0] m_pc [2];
  logic m_mis [2];
  logic [31:0] m_ras [2][DEPTH];
  int m_cnt [2];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .RAS_DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .fetch_valid_o(v[0]), .fetch_ready_i(ready), .pc_o(pc[0]),
    .is_compressed_i(comp), .branch_en(br), .jmp_en(jmp), .imm(imm), .call_i(call), .ret_i(ret),
    .redirect_i(redir), .redirect_pc_i(rpc), .trap_i(trap), .trap_vec_i(tvec), .halt_i(halt),
    .misalign_o(mis[0]));
  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(16), .RAS_DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .fetch_valid_o(v[1]), .fetch_ready_i(ready), .pc_o(pc[1]),
    .is_compressed_i(comp), .branch_en(br), .jmp_en(jmp), .imm(imm), .call_i(call), .ret_i(ret),
    .redirect_i(redir), .redirect_pc_i(rpc), .trap_i(trap), .trap_vec_i(tvec), .halt_i(halt),
    .misalign_o(mis[1]));

  // Model: state 0=boot, 1=run, 2=halted; stack top at m_ras[i][m_cnt[i]-1]
  task automatic model_step(input int i);
    logic [31:0] mask, step, tgt, seq;
    bit hit;
    mask = (i == 1) ? 32'd1 : 32'd3;
    step = (i == 1 && comp) ? 32'd2 : 32'd4;
    m_mis[i] = 1'b0;
    if (rst) begin
      m_st[i] = 0;
      m_pc[i] = RV;
      m_cnt[i] = 0;
    end else if (m_st[i] == 0) begin
      m_st[i] = 1;
    end else if (trap || redir) begin
      tgt = trap ? tvec : rpc;
      m_pc[i] = tgt & ~mask;
      m_mis[i] = (tgt & mask) != 0;
      m_st[i] = 1;
    end else begin
      if (m_st[i] == 1 && ready) begin
        hit = RAS_ON && ret && m_cnt[i] > 0;
        tgt = m_pc[i] + imm;
        seq = m_pc[i] + step;
        if (jmp || (!hit && br)) begin
          m_pc[i] = tgt & ~mask;
          m_mis[i] = (tgt & mask) != 0;
        end else if (hit) m_pc[i] = m_ras[i][m_cnt[i]-1];
        else m_pc[i] = seq;
        if (hit) m_cnt[i]--;
        if (RAS_ON && call) begin
          if (m_cnt[i] == DEPTH) begin
            for (int k = 0; k < DEPTH - 1; k++) m_ras[i][k] = m_ras[i][k+1];
            m_cnt[i] = DEPTH - 1;
          end
          m_ras[i][m_cnt[i]] = seq;
          m_cnt[i]++;
        end
      end
      if (m_st[i] == 1 && halt) m_st[i] = 2;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: dut=%h model=%h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        cmp("valid", i, 32'(v[i]), 32'(m_st[i] == 1));
        cmp("pc", i, pc[i], m_pc[i]);
        cmp("misalign", i, 32'(mis[i]), 32'(m_mis[i]));
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
    n_tests += 2;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%h expected=%h", nm, act, exp);
    end
    if (mdl !== exp) begin
      n_fail++;
      $display("FAIL %s(model): model=%h expected=%h", nm, mdl, exp);
    end
  endtask

  task automatic idle();
    {ready, comp, br, jmp, call, ret, redir, trap, halt} = '0;
    imm = '0; rpc = '0; tvec = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic go_to(input logic [31:0] a);
    redir = 1'b1; rpc = a;
    cyc();
    redir = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    lit("t1_rst_pc", pc[0], m_pc[0], RV);
    lit("t1_boot_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd0);
    cyc();
    lit("t1_run_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd1);
    lit("t1_run_pc", pc[0], m_pc[0], RV);
    go_to(32'h100);
    ready = 1'b1; cyc();
    lit("t2_acc1", pc[0], m_pc[0], 32'h104);
    ready = 1'b0; cyc();
    lit("t2_hold", pc[0], m_pc[0], 32'h104);
    ready = 1'b1; cyc();
    lit("t2_acc2", pc[0], m_pc[0], 32'h108);
    ready = 1'b0; go_to(32'h100);
    ready = 1'b1; br = 1'b1; imm = -32'sd8; cyc();
    lit("t3_branch_neg", pc[0], m_pc[0], 32'hF8);
    idle(); go_to(32'h100);
    ready = 1'b1; jmp = 1'b1; br = 1'b1; imm = 32'h20; cyc();
    lit("t3_jmp_over_br", pc[0], m_pc[0], 32'h120);
    idle();
    trap = 1'b1; tvec = 32'h200; redir = 1'b1; rpc = 32'h300; cyc();
    trap = 1'b0; redir = 1'b0;
    lit("t4_trap_prio", pc[0], m_pc[0], 32'h200);
    go_to(32'h303);
    lit("t4_mis_pc", pc[0], m_pc[0], 32'h300);
    lit("t4_mis_pc16", pc[1], m_pc[1], 32'h302);
    lit("t4_mis_pulse", 32'(mis[0]), 32'(m_mis[0]), 32'd1);
    cyc();
    lit("t4_mis_clear", 32'(mis[0]), 32'(m_mis[0]), 32'd0);
    go_to(32'hFFFF_FFFC);
    ready = 1'b1; cyc();
    lit("t5_wrap", pc[0], m_pc[0], 32'h0);
    ready = 1'b0; go_to(32'h10);
    comp = 1'b1; ready = 1'b1; cyc();
    comp = 1'b0;
    lit("t5_comp16", pc[1], m_pc[1], 32'h12);
    lit("t5_comp32", pc[0], m_pc[0], 32'h14);
    halt = 1'b1; cyc();
    halt = 1'b0;
    lit("t5_halt_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd0);
    repeat (3) cyc();
    lit("t5_halted_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd0);
    go_to(32'h40);
    lit("t5_resume_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd1);
    lit("t5_resume_pc", pc[0], m_pc[0], 32'h40);
    idle();
`ifdef PC_GEN_RAS_EN
    for (int k = 1; k <= 5; k++) begin
      go_to(32'(k * 16));
      call = 1'b1; ready = 1'b1; cyc();
      call = 1'b0; ready = 1'b0;
    end
    ret = 1'b1; ready = 1'b1;
    cyc(); lit("t6_ret1", pc[0], m_pc[0], 32'h54);
    cyc(); lit("t6_ret2", pc[0], m_pc[0], 32'h44);
    cyc(); lit("t6_ret3", pc[0], m_pc[0], 32'h34);
    cyc(); lit("t6_ret4", pc[0], m_pc[0], 32'h24);
    cyc(); lit("t6_ret_empty", pc[0], m_pc[0], 32'h28);
    idle();
`endif
    go_to(32'h60);
    call = 1'b1; ready = 1'b1; halt = 1'b1; cyc();
    idle();
    lit("t6_halted", 32'(v[0]), 32'(m_st[0] == 1), 32'd0);
    rst = 1'b1; cyc();
    rst = 1'b0;
    lit("t6_rst_pc", pc[0], m_pc[0], RV);
    lit("t6_rst_valid", 32'(v[0]), 32'(m_st[0] == 1), 32'd0);
    cyc();
    ret = 1'b1; ready = 1'b1; cyc();
    lit("t6_ras_cleared", pc[0], m_pc[0], RV + 32'd4);
    idle();
    for (int n = 0; n < 3000; n++) begin
      rst   = $urandom_range(0, 199) == 0;
      ready = $urandom_range(0, 3) != 0;
      comp  = $urandom_range(0, 1) == 1;
      br    = $urandom_range(0, 3) == 0;
      jmp   = $urandom_range(0, 7) == 0;
      call  = $urandom_range(0, 3) == 0;
      ret   = $urandom_range(0, 3) == 0;
      trap  = $urandom_range(0, 31) == 0;
      redir = $urandom_range(0, 15) == 0;
      halt  = $urandom_range(0, 15) == 0;
      imm   = 32'($urandom_range(0, 127)) - 32'd64;
      rpc   = $urandom;
      tvec  = $urandom;
      cyc();
    end
    idle();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
